// File: rtl/apb_slave_pkg.sv
// Shared types, default widths and address helper for the APB4 memory completer.
package apb_slave_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  localparam int DEFAULT_ADDR_WIDTH  = 8;
  localparam int DEFAULT_DATA_WIDTH  = 32;
  localparam int DEFAULT_MEM_DEPTH   = 64;
  localparam int DEFAULT_WAIT_CYCLES = 2;

  // Byte address to word index; lane_bits is log2 of the bytes per word.
  function automatic logic [31:0] addr_to_index(input logic [31:0] addr, input int lane_bits);
    return addr >> lane_bits;
  endfunction

endpackage

// File: rtl/apb4_mem_bank.sv
// Word-organised memory with per-byte write enables, synchronous write,
// combinational read and asynchronous clear of every word.
module apb4_mem_bank
  import apb_slave_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MEM_DEPTH  = DEFAULT_MEM_DEPTH,
  parameter int IDX_WIDTH  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [IDX_WIDTH-1:0]    wr_idx,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [IDX_WIDTH-1:0]    rd_idx,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < DATA_WIDTH / 8; b++) begin
        if (be[b]) begin
          mem[wr_idx][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/apb4_slave_mem.sv
// APB4 completer in front of apb4_mem_bank, with a fixed wait-state count per access.
// Optional APB4_PPROT_CHECK_EN: unprivileged writes to the upper half of memory fail.
module apb4_slave_mem
  import apb_slave_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int MEM_DEPTH   = DEFAULT_MEM_DEPTH,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [2:0]              PPROT,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int LANE_BITS  = $clog2(STRB_WIDTH);
  localparam int IDX_WIDTH  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  apb_state_e state, state_next;

  logic [3:0]            wait_cnt;
  logic [IDX_WIDTH-1:0]  idx_q;
  logic                  write_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] strb_q;
  logic [2:0]            prot_q;
  logic [31:0]           word_index;
  logic [IDX_WIDTH-1:0]  live_idx;
  logic                  setup_err;
  logic                  latch;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  unused_prot;

  assign word_index = addr_to_index(32'(PADDR), LANE_BITS);
  assign live_idx   = word_index[IDX_WIDTH-1:0];

`ifdef APB4_PPROT_CHECK_EN
  assign setup_err = (|(PADDR & LANE_MASK)) || (word_index >= 32'(MEM_DEPTH)) ||
                     (PWRITE && !PPROT[0] && (word_index >= 32'(MEM_DEPTH / 2)));
`else
  assign setup_err = (|(PADDR & LANE_MASK)) || (word_index >= 32'(MEM_DEPTH));
`endif

  // The latched protection bits are kept for observability but never steer the datapath.
  assign unused_prot = ^prot_q;

  assign PREADY  = (state == ACCESS) && PSEL && PENABLE && (wait_cnt == WAIT_LAST);
  assign PSLVERR = PREADY && err_q;
  assign latch   = (state_next == SETUP);
  assign mem_we  = PREADY && write_q && !err_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (PSEL && !PENABLE) state_next = SETUP;
      end
      SETUP: begin
        if (!PSEL)        state_next = IDLE;
        else if (PENABLE) state_next = ACCESS;
      end
      ACCESS: begin
        if (!PSEL)       state_next = IDLE;
        else if (PREADY) state_next = (PSEL && !PENABLE) ? SETUP : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Every edge that lands in SETUP captures a fresh request and restarts the wait count.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt <= '0;
      idx_q    <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      prot_q   <= '0;
      PRDATA   <= '0;
    end else if (latch) begin
      wait_cnt <= '0;
      idx_q    <= live_idx;
      write_q  <= PWRITE;
      err_q    <= setup_err;
      wdata_q  <= PWDATA;
      strb_q   <= PSTRB;
      prot_q   <= PPROT;
      if (!PWRITE) begin
        PRDATA <= setup_err ? '0 : rd_data;
      end
    end else if ((state == ACCESS) && (wait_cnt < WAIT_LAST)) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  apb4_mem_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_mem_bank (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .we      (mem_we),
    .be      (strb_q),
    .wr_idx  (idx_q),
    .wdata   (wdata_q),
    .rd_idx  (live_idx),
    .rd_data (rd_data)
  );

endmodule
